// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared opcode, BHT counter encodings and init value for the fetch stage
package fetch_unit_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  localparam logic [1:0] BHT_INIT = WNT;
endpackage

// File: rtl/fetch_unit_sat.sv
// sat_counter2: next state of a 2-bit saturating branch counter
module sat_counter2
  import fetch_unit_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] nxt
);
  always_comb nxt = inc ? ((cur == ST) ? ST : cur + 2'd1) : ((cur == SNT) ? SNT : cur - 2'd1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, BHT-predicted branches, stall hold and EX redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  output logic [63:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_prediction,
  output logic        if_write,
  output logic        if_flush
);
  logic [63:0] pc_reg, b_imm, next_pc;
  logic [1:0] bht [2**BHT_BITS];
  logic [1:0] upd_next;
  logic [BHT_BITS-1:0] f_idx, u_idx;
  logic is_branch, unused;
  assign f_idx = pc_reg[BHT_BITS+1:2];
  assign u_idx = upd_pc[BHT_BITS+1:2];
  assign unused = ^{upd_pc[63:BHT_BITS+2], upd_pc[1:0]};
  assign is_branch = imem_rdata[6:0] == OPC_BRANCH;
  assign b_imm = {{52{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign imem_addr = pc_reg;
  assign if_pc = pc_reg;
  assign if_instruction = imem_rdata;
  assign if_write = pc_write;
  assign if_flush = !reset && redirect_valid;
  // prediction reads the counter before any same-cycle training write lands
  assign if_prediction = !reset && is_branch && bht[f_idx][1];
  always_comb next_pc = redirect_valid ? redirect_pc :
                        !pc_write ? pc_reg :
                        if_prediction ? pc_reg + b_imm : pc_reg + 64'd4;
  sat_counter2 u_sat (.cur(bht[u_idx]), .inc(upd_taken), .nxt(upd_next));
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
      for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= BHT_INIT;
    end else begin
      pc_reg <= next_pc;
      if (upd_valid) bht[u_idx] <= upd_next;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against a queue-based reference model with scoreboard
module tb_fetch_unit;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, reset = 1, pc_write = 1, redirect_valid = 0, upd_valid = 0, upd_taken = 0;
  logic [63:0] imem_addr, redirect_pc = 0, upd_pc = 0, if_pc;
  logic [31:0] imem_rdata = NOP, if_instruction;
  logic if_prediction, if_write, if_flush;
  int checks = 0, errors = 0;
  typedef struct {logic [63:0] pc; logic [31:0] ins; logic pred, wr, fl;} exp_t;
  exp_t sbq[$];
  logic [31:0] mem [logic [63:0]];
  int m_bht [64];
  logic [63:0] m_pc;
  bit known = 0;

  fetch_unit #(.RESET_PC(RPC), .BHT_BITS(6)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_write(pc_write), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .if_pc(if_pc), .if_instruction(if_instruction), .if_prediction(if_prediction),
    .if_write(if_write), .if_flush(if_flush));

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : NOP;
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 13'd0, b[4:1], b[11], 7'b1100011};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step(input logic r, pw, rv, input logic [63:0] rpc, input logic uv,
                      input logic [63:0] upc, input logic ut);
    logic [31:0] ins;
    logic pred;
    logic signed [12:0] off;
    @(posedge clk);
    #1;
    reset = r; pc_write = pw; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    ins = known ? rd(m_pc) : NOP;
    imem_rdata = ins;
    pred = !r && known && ins[6:0] == 7'b1100011 && m_bht[m_pc[7:2]] >= 2;
    if (known) sbq.push_back('{m_pc, ins, pred, pw, !r && rv});
    off = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    if (r) begin
      m_pc = RPC;
      foreach (m_bht[i]) m_bht[i] = 1;
      known = 1;
    end else if (known) begin
      if (uv) m_bht[upc[7:2]] = ut ? (m_bht[upc[7:2]] == 3 ? 3 : m_bht[upc[7:2]] + 1)
                                   : (m_bht[upc[7:2]] == 0 ? 0 : m_bht[upc[7:2]] - 1);
      m_pc = rv ? rpc : !pw ? m_pc : pred ? m_pc + 64'(off) : m_pc + 64'd4;
    end
  endtask

  task automatic nrm(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [63:0] a);
    step(0, 1, 1, a, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("if_instruction", 64'(if_instruction), 64'(e.ins));
        chk("if_prediction", 64'(if_prediction), 64'(e.pred));
        chk("if_write", 64'(if_write), 64'(e.wr));
        chk("if_flush", 64'(if_flush), 64'(e.fl));
      end
    end
  end

  initial begin
    mem[64'h1008] = enc_b(-8);
    mem[64'h3010] = enc_b(16);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    nrm(4);
    step(0, 1, 0, 0, 1, 64'h1008, 1);
    step(0, 1, 0, 0, 1, 64'h1008, 1);
    redir(64'h1008);
    nrm(3);
    redir(64'h1004);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 64'h2000, 0, 0, 0);
    nrm(2);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 1, 64'h3010, 1);
    step(0, 1, 0, 0, 1, 64'h3010, 0);
    redir(64'h3010);
    nrm(2);
    step(1, 1, 1, 64'h5000, 1, 64'h3010, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 1, 64'h3010, 0);
    redir(64'h3010);
    nrm(2);
    step(1, 1, 0, 0, 0, 0, 0);
    redir(64'h3010);
    step(0, 0, 0, 0, 1, 64'h3010, 1);
    nrm(2);
    redir(64'hFFFF_FFFF_FFFF_FFFC);
    nrm(2);
    step(1, 0, 1, 64'h5000, 1, 64'h1008, 0);
    nrm(3);
    for (int k = 0; k < 64; k++)
      mem[64'h4000 + 64'(k * 4)] = ($urandom % 3 == 0) ? enc_b((int'($urandom_range(0, 16)) - 8) * 4) : $urandom;
    redir(64'h4000);
    for (int k = 0; k < 400; k++)
      step($urandom % 100 == 0, $urandom % 8 != 0, $urandom % 10 == 0, 64'h4000 + 64'(($urandom % 64) * 4),
           $urandom % 3 == 0, 64'h4000 + 64'(($urandom % 64) * 4), 1'($urandom % 2));
    @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
